// File: rtl/game_io_ctrl.sv
// game_io_ctrl
// Memory-mapped I/O controller sitting between the processor data-memory
// port and the data RAM. A 16-word window at IO_BASE is decoded and steered
// away from the RAM. Guitar inputs and gameclk are synchronized, strum edges
// are debounced and time-stamped with the gameclk tick count, and the
// resulting events are queued in a 4-deep FIFO drained by loads.
//
// All state changes on the falling edge of clock, matching the pipeline.
//
// Ports:
//   clock, reset          master clock (falling-edge), sync active-high reset
//   cpu_addr/data/wren    processor M-stage address, store data, store enable
//   cpu_rden              one-cycle pulse for an M-stage lw
//   cpu_q                 load data back to the processor (combinational)
//   ram_addr/data/wren    pass-through to the RAM, store masked on io hit
//   ram_q                 RAM read data
//   buttons/intersections raw asynchronous guitar inputs
//   strum, gameclk        raw asynchronous strum and game tick
module game_io_ctrl #(
  parameter logic [31:0] IO_BASE  = 32'h0000_F000,
  parameter logic [15:0] DEBOUNCE = 16'd1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data,
  input  logic        cpu_wren,
  input  logic        cpu_rden,
  output logic [31:0] cpu_q,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  input  logic [3:0]  buttons,
  input  logic [3:0]  intersections,
  input  logic        strum,
  input  logic        gameclk
);

  localparam logic [3:0] OFF_STATUS = 4'd0;
  localparam logic [3:0] OFF_EVENT  = 4'd1;
  localparam logic [3:0] OFF_TICKS  = 4'd2;
  localparam logic [3:0] OFF_CTRL   = 4'd3;

  // synchronizer chains and edge-detect delay flops
  logic [3:0]  btn_sync1_r, btn_sync2_r;
  logic [3:0]  isect_sync1_r, isect_sync2_r;
  logic        strum_sync1_r, strum_sync2_r, strum_dly_r;
  logic        gclk_sync1_r, gclk_sync2_r, gclk_dly_r;

  // core state
  logic [31:0] ticks_r;
  logic [15:0] db_cnt_r;
  logic [31:0] fifo_mem_r [4];
  logic [1:0]  wr_ptr_r, rd_ptr_r;
  logic [2:0]  count_r;
  logic        ovf_r;

  // decode / control signals
  logic        io_hit_s;
  logic [3:0]  offset_s;
  logic        strum_edge_s, gclk_edge_s;
  logic        accept_s;
  logic        ctrl_wr_s, flush_s, clr_ticks_s, clr_ovf_s;
  logic        pop_s, full_s, write_s, ovf_set_s;
  logic        empty_s;
  logic [31:0] event_word_s;
  logic [31:0] io_rdata_s;

  // address decode, edge detection and FIFO control
  always_comb begin
    io_hit_s     = (cpu_addr[31:4] == IO_BASE[31:4]);
    offset_s     = cpu_addr[3:0];
    strum_edge_s = strum_sync2_r & ~strum_dly_r;
    gclk_edge_s  = gclk_sync2_r & ~gclk_dly_r;
    // edges arriving while the debounce window is open are dropped
    accept_s     = strum_edge_s & (db_cnt_r == 16'd0);
    ctrl_wr_s    = cpu_wren & io_hit_s & (offset_s == OFF_CTRL);
    flush_s      = ctrl_wr_s & cpu_data[0];
    clr_ticks_s  = ctrl_wr_s & cpu_data[1];
    clr_ovf_s    = ctrl_wr_s & cpu_data[2];
    empty_s      = (count_r == 3'd0);
    full_s       = (count_r == 3'd4);
    pop_s        = cpu_rden & io_hit_s & (offset_s == OFF_EVENT) & ~empty_s;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    write_s      = accept_s & (~full_s | pop_s);
    ovf_set_s    = accept_s & full_s & ~pop_s & ~flush_s;
    event_word_s = {ticks_r[15:0], 7'b000_0000, 1'b1, btn_sync2_r, isect_sync2_r};
  end

  // two-flop synchronizers plus delay flops for edge detection
  always_ff @(negedge clock) begin
    if (reset) begin
      btn_sync1_r   <= 4'b0000;
      btn_sync2_r   <= 4'b0000;
      isect_sync1_r <= 4'b0000;
      isect_sync2_r <= 4'b0000;
      strum_sync1_r <= 1'b0;
      strum_sync2_r <= 1'b0;
      strum_dly_r   <= 1'b0;
      gclk_sync1_r  <= 1'b0;
      gclk_sync2_r  <= 1'b0;
      gclk_dly_r    <= 1'b0;
    end else begin
      btn_sync1_r   <= buttons;
      btn_sync2_r   <= btn_sync1_r;
      isect_sync1_r <= intersections;
      isect_sync2_r <= isect_sync1_r;
      strum_sync1_r <= strum;
      strum_sync2_r <= strum_sync1_r;
      strum_dly_r   <= strum_sync2_r;
      gclk_sync1_r  <= gameclk;
      gclk_sync2_r  <= gclk_sync1_r;
      gclk_dly_r    <= gclk_sync2_r;
    end
  end

  // game tick counter; a software clear beats a simultaneous tick
  always_ff @(negedge clock) begin
    if (reset) begin
      ticks_r <= 32'd0;
    end else if (clr_ticks_s) begin
      ticks_r <= 32'd0;
    end else if (gclk_edge_s) begin
      ticks_r <= ticks_r + 32'd1;
    end else begin
      ticks_r <= ticks_r;
    end
  end

  // strum debounce window; a DEBOUNCE of zero reloads zero and never blocks
  always_ff @(negedge clock) begin
    if (reset) begin
      db_cnt_r <= 16'd0;
    end else if (accept_s) begin
      db_cnt_r <= DEBOUNCE;
    end else if (db_cnt_r != 16'd0) begin
      db_cnt_r <= db_cnt_r - 16'd1;
    end else begin
      db_cnt_r <= db_cnt_r;
    end
  end

  // event FIFO storage, pointers and occupancy; flush wins over push/pop
  always_ff @(negedge clock) begin
    if (reset) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        fifo_mem_r[i] <= 32'd0;
      end
    end else if (flush_s) begin
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      count_r  <= 3'd0;
    end else begin
      if (write_s) begin
        fifo_mem_r[wr_ptr_r] <= event_word_s;
        wr_ptr_r             <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
      end
      case ({write_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // sticky overflow flag; software clear beats a simultaneous overflow
  always_ff @(negedge clock) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (clr_ovf_s) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // I/O register read mux
  always_comb begin
    io_rdata_s = 32'd0;
    case (offset_s)
      OFF_STATUS: io_rdata_s = {22'd0, ovf_r, count_r, empty_s, 1'b0, btn_sync2_r};
      OFF_EVENT: begin
        if (empty_s) begin
          io_rdata_s = 32'd0;
        end else begin
          io_rdata_s = fifo_mem_r[rd_ptr_r];
        end
      end
      OFF_TICKS:  io_rdata_s = ticks_r;
      default:    io_rdata_s = 32'd0;
    endcase
  end

  // processor / RAM steering
  always_comb begin
    ram_addr = cpu_addr;
    ram_data = cpu_data;
    ram_wren = cpu_wren & ~io_hit_s;
    if (io_hit_s) begin
      cpu_q = io_rdata_s;
    end else begin
      cpu_q = ram_q;
    end
  end

endmodule
